// File: rtl/adder_tree_pipe.sv
// ---------------------------------------------------------------------------
// adder_tree_pipe
//
// Fully pipelined binary adder tree. Each beat carries N_IN = 2**LEVELS
// operands which are reduced pairwise, one registered level at a time. The
// tree result then goes through an optional accumulator that sums ACC_LEN
// consecutive tree results before presenting one output word.
//
// Handshake (both ports): a word moves across a port on a rising edge where
// valid and ready are both high. The producer holds valid and data stable
// until that edge. The pipeline advances as one unit. It moves whenever the
// output register is empty or being drained (en), so in_ready is simply en.
//
// Parameters
//   WIDTH    operand width in bits
//   LEVELS   tree depth (>= 1); N_IN = 2**LEVELS operands per beat
//   ACC_LEN  tree results summed per output word (>= 1)
//   SIGNED   0: unsigned operands, 1: two's complement operands
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a beat
//   in_ready   a beat is accepted on the next edge if in_valid is high
//   in_data    packed operands, operand i = in_data[i*WIDTH +: WIDTH]
//   clr        synchronous restart of the accumulator group
//   out_valid  out_sum holds a result
//   out_ready  downstream takes out_sum on the next edge
//   out_sum    tree sum, or ACC_LEN-beat accumulated sum
// ---------------------------------------------------------------------------
module adder_tree_pipe #(
  parameter int WIDTH   = 23,
  parameter int LEVELS  = 3,
  parameter int ACC_LEN = 1,
  parameter int SIGNED  = 0,
  localparam int N_IN   = 2 ** LEVELS,
  localparam int TREE_W = WIDTH + LEVELS,
  localparam int OUT_W  = TREE_W + $clog2(ACC_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic                    clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_sum
);

  // Beat counter is at least one bit wide so the ACC_LEN=1 build still has
  // a well-formed (constant zero) counter.
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  // -------------------------------------------------------------------------
  // Global enable: the whole pipe moves unless a result is stuck at the output.
  // -------------------------------------------------------------------------
  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // -------------------------------------------------------------------------
  // Stage 0: input register.
  // vld_q[0] belongs to stage 0 and vld_q[k] to tree level k. A valid bit
  // travels with its data, so a bubble stays a bubble all the way down.
  // -------------------------------------------------------------------------
  logic [N_IN*WIDTH-1:0] in_q;
  logic [LEVELS:0]       vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      vld_q <= '0;
    end else if (en) begin
      in_q  <= in_data;
      // in_ready equals en, so in_valid alone marks an accepted beat here.
      vld_q <= {vld_q[LEVELS-1:0], in_valid};
    end
  end

  // -------------------------------------------------------------------------
  // Tree levels 1..LEVELS. Level k takes 2*NS operands of SW-1 bits. It
  // extends each one by a bit (sign or zero) and registers NS sums of SW bits.
  // Each level grows by one bit, so the sums never overflow.
  // -------------------------------------------------------------------------
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NS = N_IN >> k;
    localparam int SW = WIDTH + k;

    logic [SW-1:0] sum_q [NS];
    logic [SW-2:0] opd   [2*NS];
    logic [SW-1:0] opd_x [2*NS];

    if (k == 1) begin : g_src
      for (genvar j = 0; j < 2 * NS; j++) begin : g_opd
        assign opd[j] = in_q[j*WIDTH +: WIDTH];
      end
    end else begin : g_src
      for (genvar j = 0; j < 2 * NS; j++) begin : g_opd
        assign opd[j] = g_lvl[k-1].sum_q[j];
      end
    end

    for (genvar j = 0; j < 2 * NS; j++) begin : g_ext
      assign opd_x[j] = {(SIGNED != 0) && opd[j][SW-2], opd[j]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < NS; j++) begin
          sum_q[j] <= '0;
        end
      end else if (en) begin
        for (int j = 0; j < NS; j++) begin
          sum_q[j] <= opd_x[2*j] + opd_x[2*j+1];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tree result widened to the accumulator width.
  // -------------------------------------------------------------------------
  logic [TREE_W-1:0] tree_res;
  logic [OUT_W-1:0]  tree_ext;

  assign tree_res = g_lvl[LEVELS].sum_q[0];

  if (SIGNED != 0) begin : g_sx
    assign tree_ext = OUT_W'($signed(tree_res));
  end else begin : g_zx
    assign tree_ext = OUT_W'(tree_res);
  end

  // -------------------------------------------------------------------------
  // Accumulator and output register.
  // tree_take : the tree result is consumed on this edge.
  // group_done: that result closes a group and loads out_sum.
  // If clr arrives together with a consumed result (ACC_LEN > 1), the result
  // opens a fresh group and never closes the old one.
  // clr works regardless of en, but only touches partial_q and cnt_q.
  // -------------------------------------------------------------------------
  logic [OUT_W-1:0] partial_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tree_take;
  logic             group_done;

  assign tree_take  = vld_q[LEVELS] && en;
  assign group_done = tree_take && ((ACC_LEN == 1) || (!clr && (cnt_q == CNT_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial_q <= '0;
      cnt_q     <= '0;
    end else if (tree_take && !group_done) begin
      partial_q <= (clr ? '0 : partial_q) + tree_ext;
      cnt_q     <= (clr ? '0 : cnt_q) + CNT_W'(1);
    end else if (clr || group_done) begin
      partial_q <= '0;
      cnt_q     <= '0;
    end
  end

  // partial_q is always zero when ACC_LEN=1, so one expression serves both
  // the direct and the accumulated case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (en) begin
      out_valid <= group_done;
      if (group_done) begin
        out_sum <= partial_q + tree_ext;
      end
    end
  end

endmodule
